mcast_tag_seq: RTL and testbench

MCAST_TAG_SEQ -- requirements
Module: mcast_tag_seq

---
 rtl/mcast_pkg.sv | 24 ++
 rtl/mcast_tag_seq.sv | 196 +++++++++++++++++++
 tb/tb_mcast_tag_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mcast_pkg.sv
// Shared definitions for the multicast tag sequencer and the multicaster.
// FSM state encodings, tag/config width helpers and the config range check.
package mcast_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAST = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Tag width; a single-entry dimension still gets one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a count that must represent 1..n.
  function automatic int unsigned cfg_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic cfg_ok(input int unsigned rows, input int unsigned cols,
                                  input int unsigned nrow, input int unsigned ncol);
    return (rows != 0) && (rows <= nrow) && (cols != 0) && (cols <= ncol);
  endfunction

endpackage

// File: rtl/mcast_tag_seq.sv
// Repeats each input word once per PE row, tagging it with row and column keys.
// Optional perf counters (stall_cnt, starve_cnt) are enabled by MCAST_PERF_CNT_EN.
module mcast_tag_seq
  import mcast_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_ROW    = 4,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned WCNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [cfg_w(NUM_ROW)-1:0]   cfg_rows,
  input  logic [cfg_w(NUM_COL)-1:0]   cfg_cols,
  input  logic [WCNT_WIDTH-1:0]       cfg_words,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [tag_w(NUM_ROW)-1:0]   out_row_tag,
  output logic [tag_w(NUM_COL)-1:0]   out_col_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
`ifdef MCAST_PERF_CNT_EN
  output logic                        cfg_err,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 starve_cnt
`else
  output logic                        cfg_err
`endif
);

  localparam int unsigned CRW = cfg_w(NUM_ROW);
  localparam int unsigned CCW = cfg_w(NUM_COL);
  localparam int unsigned TRW = tag_w(NUM_ROW);
  localparam int unsigned TCW = tag_w(NUM_COL);

  logic [1:0]            state_q, state_d;
  logic [CRW-1:0]        rows_q, rows_d;
  logic [CCW-1:0]        cols_q, cols_d;
  logic [WCNT_WIDTH-1:0] words_q, words_d;
  logic [WCNT_WIDTH-1:0] acc_q, acc_d;
  logic [TCW-1:0]        next_col_q, next_col_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TRW-1:0]        row_q, row_d;
  logic [TCW-1:0]        col_q, col_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cfg_err_q, cfg_err_d;

  logic hs_c, last_row_c, more_c, in_ready_c, accept_c, ok_c, start_acc_c;

  // Next-state and datapath for the hold register and tag counters.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    words_d     = words_q;
    acc_d       = acc_q;
    next_col_d  = next_col_q;
    out_data_d  = out_data_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;

    hs_c        = out_valid_q && out_ready;
    last_row_c  = (CRW'(row_q) == rows_q - CRW'(1));
    more_c      = (acc_q != words_q);
    // Refill in the same cycle the last row beat leaves, so streaming has no bubbles.
    in_ready_c  = (state_q == ST_CAST) && more_c && (!out_valid_q || (hs_c && last_row_c));
    accept_c    = in_ready_c && in_valid;
    ok_c        = cfg_ok(32'(cfg_rows), 32'(cfg_cols), NUM_ROW, NUM_COL);
    start_acc_c = (state_q == ST_IDLE) && start && ok_c;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ok_c) begin
            rows_d      = cfg_rows;
            cols_d      = cfg_cols;
            words_d     = cfg_words;
            acc_d       = '0;
            next_col_d  = '0;
            row_d       = '0;
            col_d       = '0;
            out_valid_d = 1'b0;
            state_d     = (cfg_words == '0) ? ST_DONE : ST_CAST;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_CAST: begin
        if (hs_c) begin
          if (last_row_c) begin
            out_valid_d = 1'b0;
            if (!more_c) state_d = ST_DONE;
          end else begin
            row_d = row_q + TRW'(1);
          end
        end
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          row_d       = '0;
          col_d       = next_col_q;
          next_col_d  = (CCW'(next_col_q) == cols_q - CCW'(1)) ? '0 : next_col_q + TCW'(1);
          acc_d       = acc_q + WCNT_WIDTH'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      words_q     <= '0;
      acc_q       <= '0;
      next_col_q  <= '0;
      out_data_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      words_q     <= words_d;
      acc_q       <= acc_d;
      next_col_q  <= next_col_d;
      out_data_q  <= out_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready    = in_ready_c;
  assign out_data    = out_data_q;
  assign out_row_tag = row_q;
  assign out_col_tag = col_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

`ifdef MCAST_PERF_CNT_EN
  logic [31:0] stall_q, stall_d, starve_q, starve_d;

  // Saturating stall/starve counters, cleared by an accepted start.
  always_comb begin
    stall_d  = stall_q;
    starve_d = starve_q;
    if (start_acc_c) begin
      stall_d  = '0;
      starve_d = '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'(1);
      if ((state_q == ST_CAST) && !out_valid_q && !in_valid && (starve_q != '1))
        starve_d = starve_q + 32'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_mcast_tag_seq.sv
// Directed, table-driven bench for mcast_tag_seq with hand-written corner sequences.
module tb_mcast_tag_seq;

  logic        clk, rstn, start;
  logic [2:0]  cfg_rows, cfg_cols;
  logic [15:0] cfg_words, in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  out_row_tag, out_col_tag;
  logic        busy, done, cfg_err;
`ifdef MCAST_PERF_CNT_EN
  logic [31:0] stall_cnt, starve_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mcast_tag_seq dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_words(cfg_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_row_tag(out_row_tag), .out_col_tag(out_col_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
`ifdef MCAST_PERF_CNT_EN
    .cfg_err(cfg_err), .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`else
    .cfg_err(cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int rows; int cols; int words; int stall_at; int poke_at; int exp_beats;
  } vec_t;

  // One pass: drive words, accept beats, compare each beat with the row/col model.
  task automatic run_pass(input int rows, input int cols, input int words,
                          input int stall_at, input int poke_at, input int abort_at,
                          input int exp_beats);
    int beats = 0, sent = 0, cyc = 0, last_cyc = -1, done_cyc = -1, stall_left = 5;
    int w, r;
    @(negedge clk);
    cfg_rows = 3'(rows); cfg_cols = 3'(cols); cfg_words = 16'(words); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      if (abort_at >= 0 && beats == abort_at) return;
      out_ready = 1'b1;
      if (stall_at >= 0 && beats == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      start = (cyc == poke_at);
      if (start) begin cfg_rows = 3'd1; cfg_cols = 3'd1; cfg_words = 16'd1; end
      in_valid = 1'b1;
      in_data  = 16'hA000 + 16'(sent);
      #1;
      w = beats / rows;
      r = beats % rows;
      if (!out_ready) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(16'hA000 + 16'(w)));
        chk("stall_row", int'(out_row_tag), r);
        chk("stall_col", int'(out_col_tag), w % cols);
      end
      if (out_valid && out_ready) begin
        chk("beat_data", int'(out_data), int'(16'hA000 + 16'(w)));
        chk("beat_row", int'(out_row_tag), r);
        chk("beat_col", int'(out_col_tag), w % cols);
        beats++;
        last_cyc = cyc;
      end
      if (in_valid && in_ready) sent++;
      if (done) begin
        done_cyc = cyc;
        chk("busy_in_done", int'(busy), 1);
        chk("in_ready_in_done", int'(in_ready), 0);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("pass_timeout", int'(done_cyc >= 0), 1);
    chk("beat_count", beats, exp_beats);
    chk("words_taken", sent, words);
    chk("done_latency", done_cyc, last_cyc + 1);
    chk("done_pulse_end", int'(done), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  vec_t vecs[6];

  initial begin
    clk = 1'b0; rstn = 1'b0; start = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_words = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;

    vecs[0] = '{rows: 4, cols: 4, words: 3, stall_at: -1, poke_at: -1, exp_beats: 12};
    vecs[1] = '{rows: 2, cols: 3, words: 7, stall_at: -1, poke_at: -1, exp_beats: 14};
    vecs[2] = '{rows: 4, cols: 4, words: 2, stall_at: 2,  poke_at: -1, exp_beats: 8};
    vecs[3] = '{rows: 3, cols: 2, words: 4, stall_at: -1, poke_at: 3,  exp_beats: 12};
    vecs[4] = '{rows: 1, cols: 4, words: 5, stall_at: -1, poke_at: -1, exp_beats: 5};
    vecs[5] = '{rows: 4, cols: 1, words: 2, stall_at: 5,  poke_at: -1, exp_beats: 8};

    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_tags", int'({out_row_tag, out_col_tag}), 0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      run_pass(vecs[i].rows, vecs[i].cols, vecs[i].words,
               vecs[i].stall_at, vecs[i].poke_at, -1, vecs[i].exp_beats);
`ifdef MCAST_PERF_CNT_EN
      chk("stall_cnt", int'(stall_cnt), (vecs[i].stall_at >= 0) ? 5 : 0);
      chk("starve_cnt", int'(starve_cnt), 0);
`endif
    end

    // Zero rows and out-of-range cols are rejected without leaving IDLE.
    @(negedge clk);
    cfg_rows = 3'd0; cfg_cols = 3'd4; cfg_words = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; #1;
    chk("err_rows0_pulse", int'(cfg_err), 1);
    chk("err_rows0_busy", int'(busy), 0);
    @(negedge clk); #1;
    chk("err_rows0_end", int'(cfg_err), 0);
    chk("err_rows0_busy2", int'(busy), 0);
    @(negedge clk);
    cfg_rows = 3'd2; cfg_cols = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; #1;
    chk("err_cols5_pulse", int'(cfg_err), 1);
    chk("err_cols5_busy", int'(busy), 0);

    // Zero words goes straight to DONE with no beat.
    @(negedge clk);
    cfg_rows = 3'd2; cfg_cols = 3'd2; cfg_words = 16'd0; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; #1;
    chk("w0_done", int'(done), 1);
    chk("w0_busy", int'(busy), 1);
    chk("w0_out_valid", int'(out_valid), 0);
    chk("w0_in_ready", int'(in_ready), 0);
    chk("w0_cfg_err", int'(cfg_err), 0);
    @(negedge clk); #1;
    chk("w0_done_end", int'(done), 0);
    chk("w0_busy_end", int'(busy), 0);
    chk("w0_out_valid2", int'(out_valid), 0);
    in_valid = 1'b0;

    // Reset mid-pass drops the partial word; a fresh pass starts clean.
    run_pass(4, 4, 3, -1, -1, 5, 12);
    rstn = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_tags", int'({out_row_tag, out_col_tag}), 0);
    @(negedge clk);
    rstn = 1'b1;
    run_pass(1, 1, 2, -1, -1, -1, 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
